// File: rtl/nn_cfg_master_if.sv
// AXI4-Lite bus bundle between the configuration sequencer (master) and the
// accelerator's configuration slave.
interface nn_cfg_master_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/nn_cfg_master.sv
// Standalone AXI4-Lite configuration sequencer: replays an {addr,data} write
// script, then optionally waits for the accelerator interrupt and reads the result.
module nn_cfg_master #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int SCRIPT_AW          = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] RESULT_ADDR = 5'h08,
    parameter int TIMEOUT_CYCLES     = 1048576
) (
    input  logic                                         s_axi_aclk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic [SCRIPT_AW:0]                           script_len,
    input  logic                                         read_result,
    output logic                                         scr_rd_en,
    output logic [SCRIPT_AW-1:0]                         scr_addr,
    input  logic [C_S_AXI_ADDR_WIDTH+C_S_AXI_DATA_WIDTH-1:0] scr_data,
    nn_cfg_master_if.master                              m_axi,
    input  logic                                         intr,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                result,
    output logic                                         result_valid
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int IDX_W  = SCRIPT_AW + 1;
    localparam logic [31:0] TIMEOUT_LAST_C = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH      = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_WRITE      = 4'd3,
        ST_RESP       = 4'd4,
        ST_WAIT_INTR  = 4'd5,
        ST_READ_AR    = 4'd6,
        ST_READ_R     = 4'd7,
        ST_DONE       = 4'd8
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  len_r;
    logic [IDX_W-1:0]  idx_r;
    logic              rd_req_r;
    logic [AW-1:0]     awaddr_r;
    logic [DW-1:0]     wdata_r;
    logic              awvalid_r;
    logic              wvalid_r;
    logic              aw_done_r;
    logic              w_done_r;
    logic              bready_r;
    logic              arvalid_r;
    logic              rready_r;
    logic              scr_rd_en_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic [DW-1:0]     result_r;
    logic              result_valid_r;
    logic [31:0]       wait_cnt_r;

    logic              aw_hs_s;
    logic              w_hs_s;
    logic              ar_hs_s;
    logic [IDX_W-1:0]  idx_next_s;

    assign aw_hs_s    = awvalid_r & m_axi.awready;
    assign w_hs_s     = wvalid_r & m_axi.wready;
    assign ar_hs_s    = arvalid_r & m_axi.arready;
    assign idx_next_s = idx_r + IDX_W'(1);

    // Sequencer FSM; every output is a register so valids never follow ready combinationally
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            len_r          <= '0;
            idx_r          <= '0;
            rd_req_r       <= 1'b0;
            awaddr_r       <= '0;
            wdata_r        <= '0;
            awvalid_r      <= 1'b0;
            wvalid_r       <= 1'b0;
            aw_done_r      <= 1'b0;
            w_done_r       <= 1'b0;
            bready_r       <= 1'b0;
            arvalid_r      <= 1'b0;
            rready_r       <= 1'b0;
            scr_rd_en_r    <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            wait_cnt_r     <= 32'd0;
        end else begin
            done_r         <= 1'b0;
            result_valid_r <= 1'b0;
            scr_rd_en_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r      <= script_len;
                        rd_req_r   <= read_result;
                        idx_r      <= '0;
                        error_r    <= 1'b0;
                        wait_cnt_r <= 32'd0;
                        if (script_len != '0) begin
                            scr_rd_en_r <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_FETCH;
                        end else if (read_result) begin
                            busy_r  <= 1'b1;
                            state_r <= ST_WAIT_INTR;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    awaddr_r  <= scr_data[AW+DW-1:DW];
                    wdata_r   <= scr_data[DW-1:0];
                    awvalid_r <= 1'b1;
                    wvalid_r  <= 1'b1;
                    aw_done_r <= 1'b0;
                    w_done_r  <= 1'b0;
                    state_r   <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    // The two channels may complete in either order or together
                    if ((aw_done_r | aw_hs_s) && (w_done_r | w_hs_s)) begin
                        bready_r <= 1'b1;
                        state_r  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_r <= 1'b0;
                        if (m_axi.bresp != 2'b00) begin
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            idx_r <= idx_next_s;
                            if (idx_next_s != len_r) begin
                                scr_rd_en_r <= 1'b1;
                                state_r     <= ST_FETCH;
                            end else if (rd_req_r) begin
                                wait_cnt_r <= 32'd0;
                                state_r    <= ST_WAIT_INTR;
                            end else begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                        end
                    end
                end
                ST_WAIT_INTR: begin
                    if (intr) begin
                        arvalid_r <= 1'b1;
                        state_r   <= ST_READ_AR;
                    end else if (wait_cnt_r == TIMEOUT_LAST_C) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
                end
                ST_READ_AR: begin
                    if (ar_hs_s) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_READ_R;
                    end
                end
                ST_READ_R: begin
                    if (m_axi.rvalid) begin
                        // A slave error still updates result so the raw data is visible
                        result_r       <= m_axi.rdata;
                        result_valid_r <= 1'b1;
                        rready_r       <= 1'b0;
                        if (m_axi.rresp != 2'b00) begin
                            error_r <= 1'b1;
                        end
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign scr_rd_en     = scr_rd_en_r;
    assign scr_addr      = idx_r[SCRIPT_AW-1:0];
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign result        = result_r;
    assign result_valid  = result_valid_r;

    assign m_axi.awaddr  = awaddr_r;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_r;
    assign m_axi.wdata   = wdata_r;
    assign m_axi.wstrb   = {STRB_W{1'b1}};
    assign m_axi.wvalid  = wvalid_r;
    assign m_axi.bready  = bready_r;
    assign m_axi.araddr  = RESULT_ADDR;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_r;
    assign m_axi.rready  = rready_r;
endmodule

// File: tb/tb_nn_cfg_master.sv
// Directed bench for nn_cfg_master: script memory, configurable-latency
// AXI4-Lite slave model and immediate-assertion checks.
module tb_nn_cfg_master;
    logic        s_axi_aclk;
    logic        reset;
    logic        start;
    logic [10:0] script_len;
    logic        read_result;
    logic        scr_rd_en;
    logic [9:0]  scr_addr;
    logic [36:0] scr_data;
    logic        intr;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic        result_valid;

    int checks = 0;
    int errors = 0;

    nn_cfg_master_if #(.ADDR_W(5), .DATA_W(32)) axi ();

    nn_cfg_master #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .SCRIPT_AW(10),
        .RESULT_ADDR(5'h08),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .s_axi_aclk(s_axi_aclk),
        .reset(reset),
        .start(start),
        .script_len(script_len),
        .read_result(read_result),
        .scr_rd_en(scr_rd_en),
        .scr_addr(scr_addr),
        .scr_data(scr_data),
        .m_axi(axi),
        .intr(intr),
        .busy(busy),
        .done(done),
        .error(error),
        .result(result),
        .result_valid(result_valid)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    // Script memory: one-cycle read latency
    logic [36:0] mem [0:15];
    always @(posedge s_axi_aclk) begin
        if (scr_rd_en) scr_data <= mem[scr_addr[3:0]];
    end

    // Slave model with programmable ready latency and injected write error
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          err_at   = -1;
    logic [31:0] rdata_val = 32'd0;
    logic [1:0]  rresp_val = 2'b00;
    int          aw_cnt = 0, w_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [4:0]  cur_addr = 5'd0;
    logic [31:0] cur_data = 32'd0;
    logic [3:0]  cur_strb = 4'd0;
    int          wr_count = 0, aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
    logic [4:0]  ar_last_addr = 5'd0;
    logic [36:0] wr_log [0:63];
    logic [3:0]  wr_strb_log [0:63];
    logic        aw_hs, w_hs;

    assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);
    assign axi.arready = axi.arvalid;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;

    always @(posedge s_axi_aclk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rdata <= 32'd0; axi.rresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1; cur_addr <= axi.awaddr; aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1;
            end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                w_got <= 1'b1; cur_data <= axi.wdata; cur_strb <= axi.wstrb; w_cnt <= 0;
                w_hs_cnt <= w_hs_cnt + 1;
            end else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= (wr_count == err_at) ? 2'b10 : 2'b00;
                wr_log[wr_count[5:0]] <= {(aw_hs ? axi.awaddr : cur_addr), (w_hs ? axi.wdata : cur_data)};
                wr_strb_log[wr_count[5:0]] <= w_hs ? axi.wstrb : cur_strb;
                wr_count <= wr_count + 1;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1; axi.rdata <= rdata_val; axi.rresp <= rresp_val;
                ar_hs_cnt <= ar_hs_cnt + 1; ar_last_addr <= axi.araddr;
            end else if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // Activity monitors
    int awv_cnt = 0, wv_cnt = 0, arv_cnt = 0, rv_pulse_cnt = 0, done_cnt = 0, fetch_cnt = 0;
    always @(posedge s_axi_aclk) begin
        if (axi.awvalid) awv_cnt <= awv_cnt + 1;
        if (axi.wvalid) wv_cnt <= wv_cnt + 1;
        if (axi.arvalid) arv_cnt <= arv_cnt + 1;
        if (result_valid) rv_pulse_cnt <= rv_pulse_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (scr_rd_en) fetch_cnt <= fetch_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [10:0] len, input logic rr);
        script_len  = len;
        read_result = rr;
        start       = 1'b1;
        @(negedge s_axi_aclk);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int c = 0;
        while (done !== 1'b1 && c < max) begin
            @(negedge s_axi_aclk);
            c++;
        end
        check(tag, 64'(done), 64'(1'b1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int base_wr, base_fetch, base_aw, base_w, base_awv, base_wv, base_ar, base_arv, base_rv, base_done, cyc;

    initial begin
        reset = 1'b1; start = 1'b0; script_len = 11'd0; read_result = 1'b0; intr = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 37'd0;
        mem[0] = {5'h0C, 32'h0000_0001};
        mem[1] = {5'h10, 32'h0000_0002};
        mem[2] = {5'h00, 32'h0000_ABCD};
        repeat (3) @(negedge s_axi_aclk);
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done_err", 64'({done, error, result_valid}), 64'(3'b000));
        check("rst_result", 64'(result), 64'(32'd0));
        check("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, scr_rd_en}), 64'(6'd0));
        @(negedge s_axi_aclk);

        // Zero-wait three-entry script
        base_wr = wr_count;
        pulse_start(11'd3, 1'b0);
        check("t1_fetch_k1", 64'({scr_rd_en, busy}), 64'(2'b11));
        check("t1_scr_addr0", 64'(scr_addr), 64'(10'd0));
        @(negedge s_axi_aclk);
        check("t1_awvalid_k2", 64'({axi.awvalid, scr_rd_en}), 64'(2'b00));
        @(negedge s_axi_aclk);
        check("t1_valids_k3", 64'({axi.awvalid, axi.wvalid}), 64'(2'b11));
        check("t1_payload_k3", 64'({axi.awaddr, axi.wdata}), 64'({5'h0C, 32'h0000_0001}));
        check("t1_strb_prot", 64'({axi.wstrb, axi.awprot}), 64'({4'hF, 3'b000}));
        wait_done(100, "t1_done");
        check("t1_error", 64'(error), 64'(1'b0));
        check("t1_busy_in_done", 64'(busy), 64'(1'b0));
        check("t1_nwrites", 64'(wr_count - base_wr), 64'(3));
        check("t1_wr0", 64'(wr_log[base_wr]), 64'({5'h0C, 32'h0000_0001}));
        check("t1_wr1", 64'(wr_log[base_wr+1]), 64'({5'h10, 32'h0000_0002}));
        check("t1_wr2", 64'(wr_log[base_wr+2]), 64'({5'h00, 32'h0000_ABCD}));
        check("t1_strb2", 64'(wr_strb_log[base_wr+2]), 64'(4'hF));
        @(negedge s_axi_aclk);
        check("t1_done_pulse", 64'(done), 64'(1'b0));

        // AW ready delayed three cycles, W ready immediate
        aw_delay = 3;
        base_wr = wr_count; base_aw = aw_hs_cnt; base_w = w_hs_cnt; base_awv = awv_cnt; base_wv = wv_cnt;
        pulse_start(11'd3, 1'b0);
        wait_done(200, "t2_done");
        @(negedge s_axi_aclk);
        check("t2_awvalid_cycles", 64'(awv_cnt - base_awv), 64'(12));
        check("t2_wvalid_cycles", 64'(wv_cnt - base_wv), 64'(3));
        check("t2_aw_hs", 64'(aw_hs_cnt - base_aw), 64'(3));
        check("t2_w_hs", 64'(w_hs_cnt - base_w), 64'(3));
        check("t2_wr1", 64'(wr_log[base_wr+1]), 64'({5'h10, 32'h0000_0002}));
        aw_delay = 0;

        // SLVERR on second entry aborts the script
        base_wr = wr_count; base_fetch = fetch_cnt; base_done = done_cnt;
        err_at = wr_count + 1;
        pulse_start(11'd3, 1'b0);
        wait_done(100, "t3_done");
        check("t3_error", 64'(error), 64'(1'b1));
        @(negedge s_axi_aclk);
        check("t3_fetches", 64'(fetch_cnt - base_fetch), 64'(2));
        check("t3_nwrites", 64'(wr_count - base_wr), 64'(2));
        check("t3_done_count", 64'(done_cnt - base_done), 64'(1));
        check("t3_error_sticky", 64'(error), 64'(1'b1));
        err_at = -1;

        // No script, interrupt after 20 cycles, read result
        rdata_val = 32'd7; rresp_val = 2'b00;
        base_ar = ar_hs_cnt; base_rv = rv_pulse_cnt; base_done = done_cnt;
        pulse_start(11'd0, 1'b1);
        check("t4_error_cleared", 64'(error), 64'(1'b0));
        check("t4_busy", 64'(busy), 64'(1'b1));
        repeat (20) @(negedge s_axi_aclk);
        check("t4_no_ar_before_intr", 64'(axi.arvalid), 64'(1'b0));
        intr = 1'b1;
        wait_done(50, "t4_done");
        intr = 1'b0;
        check("t4_result", 64'(result), 64'(32'd7));
        check("t4_error", 64'(error), 64'(1'b0));
        @(negedge s_axi_aclk);
        check("t4_rv_cleared", 64'(result_valid), 64'(1'b0));
        check("t4_rv_pulses", 64'(rv_pulse_cnt - base_rv), 64'(1));
        check("t4_ar_count", 64'(ar_hs_cnt - base_ar), 64'(1));
        check("t4_araddr", 64'(ar_last_addr), 64'(5'h08));
        check("t4_result_held", 64'(result), 64'(32'd7));

        // Interrupt never arrives: timeout after 64 cycles in WAIT_INTR
        base_arv = arv_cnt;
        pulse_start(11'd0, 1'b1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge s_axi_aclk);
            cyc++;
        end
        check("t5_timeout_cycles", 64'(cyc), 64'(64));
        check("t5_error", 64'(error), 64'(1'b1));
        check("t5_no_arvalid", 64'(arv_cnt - base_arv), 64'(0));
        @(negedge s_axi_aclk);

        // Reset while AW is stalled, then replay from entry 0
        aw_delay = 100;
        pulse_start(11'd3, 1'b0);
        @(negedge s_axi_aclk);
        @(negedge s_axi_aclk);
        check("t6_aw_pending", 64'({axi.awvalid, axi.awready}), 64'(2'b10));
        reset = 1'b1;
        @(negedge s_axi_aclk);
        reset = 1'b0;
        check("t6_valids_dropped", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'(5'd0));
        check("t6_busy_error", 64'({busy, error, scr_rd_en}), 64'(3'b000));
        aw_delay = 0;
        @(negedge s_axi_aclk);
        base_wr = wr_count;
        pulse_start(11'd3, 1'b0);
        check("t6_restart_addr", 64'({scr_rd_en, scr_addr}), 64'({1'b1, 10'd0}));
        wait_done(100, "t6_done");
        check("t6_nwrites", 64'(wr_count - base_wr), 64'(3));
        check("t6_wr0", 64'(wr_log[base_wr]), 64'({5'h0C, 32'h0000_0001}));
        check("t6_error", 64'(error), 64'(1'b0));
        @(negedge s_axi_aclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
